// File: rtl/aes_round_state_seq.sv
// AES round sequencer: holds the 128-bit cipher state, steps round_idx for the key schedule, and registers the round-cone result.
// Optional build macro AES_ROUND_ABORT_EN adds an 'abort' input that drops the block in flight.
module aes_round_state_seq #(
  parameter int NR = 10,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef AES_ROUND_ABORT_EN
  input  logic          abort,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [DW-1:0] round_key,
  output logic [3:0]    round_idx,
  output logic [DW-1:0] rl_state,
  output logic          rl_last,
  input  logic [DW-1:0] rl_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  localparam logic [3:0] LAST_IDX = 4'(NR);

  fsm_t          fsm;
  logic [DW-1:0] state_q;
  logic          abort_hit;

`ifdef AES_ROUND_ABORT_EN
  // abort is only meaningful while a block is in flight; in IDLE it is ignored
  assign abort_hit = abort && (fsm != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign rl_state = state_q;
  assign out_data = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n || abort_hit) begin
      fsm       <= IDLE;
      state_q   <= '0;
      round_idx <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      rl_last   <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          // round_idx is 0 here, so round_key is the whitening key
          if (in_valid && in_ready) begin
            state_q   <= in_data ^ round_key;
            round_idx <= 4'd1;
            rl_last   <= (LAST_IDX == 4'd1);
            in_ready  <= 1'b0;
            fsm       <= ROUND;
          end
        end
        ROUND: begin
          state_q <= rl_result;
          if (round_idx == LAST_IDX) begin
            rl_last   <= 1'b0;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            round_idx <= round_idx + 4'd1;
            rl_last   <= ((round_idx + 4'd1) == LAST_IDX);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            round_idx <= '0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: begin
          fsm       <= IDLE;
          round_idx <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          rl_last   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_state_seq.sv
// Directed bench for aes_round_state_seq: NR=10 and NR=14 instances, stub and real AES-128 round cones.
// Build with AES_ROUND_ABORT_EN defined to also exercise the abort input.
module tb_aes_round_state_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, out_ready, sel14, real_mode;
  logic [127:0] in_data;
  logic [127:0] ks [0:15];
`ifdef AES_ROUND_ABORT_EN
  logic         abort;
`endif

  logic         ir_a, ov_a, last_a, ir_b, ov_b, last_b;
  logic [3:0]   idx_a, idx_b;
  logic [127:0] st_a, od_a, rk_a, res_a, st_b, od_b, rk_b, res_b;
  logic         ir, ov, last;
  logic [3:0]   idx;
  logic [127:0] st, od;

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, sq, b, s;
    r = 8'h01; sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    b = r;
    s = b ^ ((b << 1) | (b >> 7)) ^ ((b << 2) | (b >> 6)) ^ ((b << 3) | (b >> 5)) ^ ((b << 4) | (b >> 4)) ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] aesRound(input logic [127:0] s, input logic lst);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   m0, m1, m2, m3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (!lst) begin
      for (int c = 0; c < 4; c++) begin
        m0 = b[4*c]; m1 = b[4*c+1]; m2 = b[4*c+2]; m3 = b[4*c+3];
        b[4*c]   = gmul(m0, 8'h02) ^ gmul(m1, 8'h03) ^ m2 ^ m3;
        b[4*c+1] = m0 ^ gmul(m1, 8'h02) ^ gmul(m2, 8'h03) ^ m3;
        b[4*c+2] = m0 ^ m1 ^ gmul(m2, 8'h02) ^ gmul(m3, 8'h03);
        b[4*c+3] = gmul(m0, 8'h03) ^ m1 ^ m2 ^ gmul(m3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o;
  endfunction

  task automatic expandKey(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) ks[r] = '0;
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] keyFor(input int k);
    logic [3:0] k4;
    k4 = 4'(k);
    return real_mode ? ks[k4] : {124'h0, k4};
  endfunction

  always_comb rk_a  = real_mode ? ks[idx_a] : {124'h0, idx_a};
  always_comb res_a = real_mode ? (aesRound(st_a, last_a) ^ rk_a) : (st_a ^ rk_a);
  always_comb rk_b  = real_mode ? ks[idx_b] : {124'h0, idx_b};
  always_comb res_b = real_mode ? (aesRound(st_b, last_b) ^ rk_b) : (st_b ^ rk_b);

  assign ir   = sel14 ? ir_b   : ir_a;
  assign ov   = sel14 ? ov_b   : ov_a;
  assign last = sel14 ? last_b : last_a;
  assign idx  = sel14 ? idx_b  : idx_a;
  assign st   = sel14 ? st_b   : st_a;
  assign od   = sel14 ? od_b   : od_a;

  aes_round_state_seq #(.NR(10), .DW(128)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_ROUND_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid & ~sel14), .in_ready(ir_a), .in_data(in_data), .round_key(rk_a),
    .round_idx(idx_a), .rl_state(st_a), .rl_last(last_a), .rl_result(res_a),
    .out_valid(ov_a), .out_ready(out_ready & ~sel14), .out_data(od_a)
  );

  aes_round_state_seq #(.NR(14), .DW(128)) dut14 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_ROUND_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid & sel14), .in_ready(ir_b), .in_data(in_data), .round_key(rk_b),
    .round_idx(idx_b), .rl_state(st_b), .rl_last(last_b), .rl_result(res_b),
    .out_valid(ov_b), .out_ready(out_ready & sel14), .out_data(od_b)
  );

  typedef struct {
    logic         use14;
    logic         real_mode;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           hold;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    while (ir !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("in_ready_wait", 128'(ir), 128'(1));
  endtask

  task automatic applyStimulus(input vec_t v);
    int           nr;
    logic [127:0] mst;
    sel14     = v.use14;
    real_mode = v.real_mode;
    if (v.real_mode) expandKey(v.key);
    nr = v.use14 ? 14 : 10;
    waitReady();
    in_valid = 1'b1;
    in_data  = v.pt;
    mst      = v.pt ^ keyFor(0);
    tick();
    // keep a different block offered while busy; it must be ignored
    in_data = ~v.pt;
    for (int k = 1; k <= nr; k++) begin
      checkOutput("round_idx", 128'(idx), 128'(k));
      checkOutput("rl_last", 128'(last), 128'(k == nr));
      checkOutput("rl_state", st, mst);
      checkOutput("busy_in_ready", 128'(ir), 128'(0));
      checkOutput("early_out_valid", 128'(ov), 128'(0));
      mst = v.real_mode ? (aesRound(mst, k == nr) ^ keyFor(k)) : (mst ^ keyFor(k));
      tick();
    end
    checkOutput("out_valid", 128'(ov), 128'(1));
    checkOutput("ciphertext", od, v.ct);
    checkOutput("done_rl_state", st, v.ct);
    checkOutput("done_idx", 128'(idx), 128'(nr));
    checkOutput("done_in_ready", 128'(ir), 128'(0));
    checkOutput("done_rl_last", 128'(last), 128'(0));
    for (int h = 0; h < v.hold; h++) begin
      tick();
      checkOutput("hold_out_data", od, v.ct);
      checkOutput("hold_out_valid", 128'(ov), 128'(1));
      checkOutput("hold_in_ready", 128'(ir), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("handoff_out_valid", 128'(ov), 128'(0));
    checkOutput("handoff_in_ready", 128'(ir), 128'(1));
    checkOutput("handoff_idx", 128'(idx), 128'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // stub cones XOR the round index in each round: NR=10 adds XOR(0..10)=0xB, NR=14 adds XOR(0..14)=0xF
    vecs[0] = '{1'b0, 1'b0, 128'h0, 128'h1, 128'ha, 0};
    vecs[1] = '{1'b0, 1'b0, 128'h0, 128'h0123456789abcdef_fedcba9876543210,
                128'h0123456789abcdef_fedcba987654321b, 20};
    vecs[2] = '{1'b0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 3};
    vecs[3] = '{1'b0, 1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 0};
    vecs[4] = '{1'b1, 1'b0, 128'h0, 128'h1, 128'he, 2};
    vecs[5] = '{1'b1, 1'b0, 128'h0, {128{1'b1}}, {{124{1'b1}}, 4'h0}, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel14 = 1'b0; real_mode = 1'b0; in_data = '0;
`ifdef AES_ROUND_ABORT_EN
    abort = 1'b0;
`endif
    for (int r = 0; r < 16; r++) ks[r] = '0;
    tick();
    tick();
    checkOutput("rst_in_ready", 128'(ir_a), 128'(1));
    checkOutput("rst_out_valid", 128'(ov_a), 128'(0));
    checkOutput("rst_idx", 128'(idx_a), 128'(0));
    checkOutput("rst_state", st_a, 128'h0);
    checkOutput("rst14_in_ready", 128'(ir_b), 128'(1));
    checkOutput("rst14_idx", 128'(idx_b), 128'(0));
    rst_n = 1'b1;
    tick();

    // reset while in round 5 must discard the block
    waitReady();
    in_valid = 1'b1; in_data = 128'h1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    checkOutput("mid_idx_before_rst", 128'(idx_a), 128'(5));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("mid_rst_in_ready", 128'(ir_a), 128'(1));
    checkOutput("mid_rst_out_valid", 128'(ov_a), 128'(0));
    checkOutput("mid_rst_idx", 128'(idx_a), 128'(0));
    checkOutput("mid_rst_state", st_a, 128'h0);
    checkOutput("mid_rst_rl_last", 128'(last_a), 128'(0));
    tick();
    checkOutput("post_rst_idle_idx", 128'(idx_a), 128'(0));

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

`ifdef AES_ROUND_ABORT_EN
    begin
      logic seen_ov;
      sel14 = 1'b0; real_mode = 1'b0;
      waitReady();
      in_valid = 1'b1; in_data = 128'h5; abort = 1'b1;
      tick();
      in_valid = 1'b0; abort = 1'b0;
      checkOutput("abort_idle_accept_idx", 128'(idx_a), 128'(1));
      checkOutput("abort_idle_in_ready", 128'(ir_a), 128'(0));
      tick();
      tick();
      checkOutput("abort_round3_idx", 128'(idx_a), 128'(3));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort_round_idx", 128'(idx_a), 128'(0));
      checkOutput("abort_round_in_ready", 128'(ir_a), 128'(1));
      checkOutput("abort_round_state", st_a, 128'h0);
      seen_ov = ov_a;
      for (int k = 0; k < 15; k++) begin
        tick();
        seen_ov = seen_ov | ov_a;
      end
      checkOutput("abort_no_out_valid", 128'(seen_ov), 128'(0));
      in_valid = 1'b1; in_data = 128'h1;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 10; k++) tick();
      checkOutput("abort_done_reached", 128'(ov_a), 128'(1));
      abort = 1'b1; out_ready = 1'b1;
      tick();
      abort = 1'b0; out_ready = 1'b0;
      checkOutput("abort_done_out_valid", 128'(ov_a), 128'(0));
      checkOutput("abort_done_state", st_a, 128'h0);
      checkOutput("abort_done_in_ready", 128'(ir_a), 128'(1));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
